mac_window_engine: RTL

- Parametrised successor to the single-cycle MAC array: NUM_LANES signed multiply-accumulate lanes, fixed-length accumulation window (WIN_LEN accepted beats), registered multiply stage, lane-sum reduction and valid/ready output handshake.
- Sits between the window/line-buffer feeder and the activation/requantise stage.
- Emits one dot product per window, then holds its result until it is consumed.

---
 rtl/mac_window_engine.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mac_window_engine.sv
// mac_window_engine: NUM_LANES signed MAC lanes accumulating over a fixed
// window of WIN_LEN accepted beats. Each lane product is registered, then
// added to its accumulator. The lane accumulators are reduced into dot_out,
// which is held under a valid/ready handshake until the consumer takes it.
// Optional feature macro MAC_WINDOW_SATURATE_EN: when defined, accumulator
// adds clamp to the ACC_W signed range and ovf records any clamp. When it is
// undefined, accumulators wrap and ovf is tied low.
module mac_window_engine #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int WIN_LEN   = 9,
    localparam int CNT_W    = $clog2(WIN_LEN + 1),
    localparam int DOT_W    = ACC_W + $clog2(NUM_LANES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*DATA_W-1:0]    a_flat,
    input  logic [NUM_LANES*DATA_W-1:0]    b_flat,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*ACC_W-1:0]     acc_flat,
    output logic signed [DOT_W-1:0]        dot_out,
    output logic [CNT_W-1:0]               beat_cnt,
    output logic                           busy,
    output logic                           ovf
);

    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t state, next_state;

    logic                     accept;
    logic                     clear;
    logic                     last_beat;
    logic                     dot_load;

    logic signed [PROD_W-1:0] prod_c  [NUM_LANES];
    logic signed [PROD_W-1:0] prod_p0 [NUM_LANES];
    logic                     vld_p0;
    logic signed [ACC_W-1:0]  acc_nxt [NUM_LANES];
    logic signed [ACC_W-1:0]  acc_p1  [NUM_LANES];
    logic signed [DOT_W-1:0]  dot_c;
    logic signed [DOT_W-1:0]  dot_p2;
    logic [CNT_W-1:0]         cnt;

`ifdef MAC_WINDOW_SATURATE_EN
    logic [NUM_LANES-1:0]     clamp;
    logic                     ovf_r;

    // One-bit-wider sum so that a signed overflow shows up as a sign-bit split
    function automatic logic signed [ACC_W:0] wide_add(
        input logic signed [ACC_W-1:0] x,
        input logic signed [ACC_W-1:0] y
    );
        return (ACC_W + 1)'(x) + (ACC_W + 1)'(y);
    endfunction

    // Clamp a wide sum back into the ACC_W signed range
    function automatic logic signed [ACC_W-1:0] saturate(
        input logic signed [ACC_W:0] s
    );
        logic signed [ACC_W-1:0] res;
        if (s[ACC_W] != s[ACC_W-1]) begin
            res = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            res = s[ACC_W-1:0];
        end
        return res;
    endfunction
`endif

    // A start outside DONE restarts the window; a start also wins over a same-cycle beat
    assign clear     = start && (state != DONE);
    assign accept    = in_valid && (state == ACCUM) && !start;
    assign last_beat = (cnt == CNT_W'(WIN_LEN - 1));
    assign dot_load  = (state == DRAIN) && !vld_p0 && !start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; DRAIN waits until the last product has been accumulated
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCUM;
            ACCUM: begin
                if (start)                      next_state = ACCUM;
                else if (accept && last_beat)   next_state = DRAIN;
            end
            DRAIN: begin
                if (start)        next_state = ACCUM;
                else if (!vld_p0) next_state = DONE;
            end
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = (state == ACCUM);
        busy      = (state == ACCUM) || (state == DRAIN);
        out_valid = (state == DONE);
    end

    // Per-lane signed products at full 2*DATA_W precision
    always_comb begin
        logic signed [DATA_W-1:0] a_l;
        logic signed [DATA_W-1:0] b_l;
        a_l = '0;
        b_l = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            a_l       = a_flat[i*DATA_W +: DATA_W];
            b_l       = b_flat[i*DATA_W +: DATA_W];
            prod_c[i] = PROD_W'(a_l) * PROD_W'(b_l);
        end
    end

    // Next accumulator values: sign-extended product added with wrap or clamp
    always_comb begin
        logic signed [ACC_W-1:0] ext;
`ifdef MAC_WINDOW_SATURATE_EN
        logic signed [ACC_W:0]   sum_w;
        clamp = '0;
        sum_w = '0;
`endif
        ext = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            ext = ACC_W'(prod_p0[i]);
`ifdef MAC_WINDOW_SATURATE_EN
            sum_w      = wide_add(acc_p1[i], ext);
            acc_nxt[i] = saturate(sum_w);
            clamp[i]   = sum_w[ACC_W] ^ sum_w[ACC_W-1];
`else
            acc_nxt[i] = acc_p1[i] + ext;
`endif
        end
    end

    // Lane reduction at DOT_W so the sum cannot overflow
    always_comb begin
        dot_c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            dot_c = dot_c + DOT_W'(acc_p1[i]);
        end
    end

    // Stage p0: register lane products for accepted beats with their valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) prod_p0[i] <= '0;
        end else begin
            vld_p0 <= accept;
            if (accept) prod_p0 <= prod_c;
        end
    end

    // Stage p1: accumulate valid products; a restart clears the lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) acc_p1[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_LANES; i++) acc_p1[i] <= '0;
        end else if (vld_p0) begin
            acc_p1 <= acc_nxt;
        end
    end

    // Count beats accepted in the current window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (accept) cnt <= cnt + 1'b1;
    end

    // Stage p2: capture the lane sum once the pipeline has drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        dot_p2 <= '0;
        else if (dot_load) dot_p2 <= dot_c;
    end

`ifdef MAC_WINDOW_SATURATE_EN
    // Sticky per-window clamp flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  ovf_r <= 1'b0;
        else if (clear)              ovf_r <= 1'b0;
        else if (vld_p0 && |clamp)   ovf_r <= 1'b1;
    end
    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_acc_out
        assign acc_flat[g*ACC_W +: ACC_W] = acc_p1[g];
    end

    assign dot_out  = dot_p2;
    assign beat_cnt = cnt;

endmodule
